// File: rtl/dpr_fifo_ctrl_if.sv
// Consumer/producer-facing FIFO bus for dpr_fifo_ctrl.
// The master side pushes and pops; the slave side is the FIFO controller.
interface dpr_fifo_ctrl_if #(
  parameter int a_width = 4,
  parameter int d_width = 8
);
  logic               wr_req;
  logic [d_width-1:0] din;
  logic               rd_req;
  logic [d_width-1:0] dout;
  logic               rd_valid;
  logic               full;
  logic               empty;
  logic [a_width:0]   count;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_req, din, rd_req,
    input  dout, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_req, din, rd_req,
    output dout, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/dpr_fifo_ctrl.sv
// Single-clock FIFO controller driving a dual-port RAM: port 1 writes at wr_ptr,
// port 2 reads at rd_ptr with one cycle of registered read latency.
module dpr_fifo_ctrl #(
  parameter int a_width = 4,
  parameter int d_width = 8,
  parameter int a_depth = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dpr_fifo_ctrl_if.slave     bus,
  output logic [a_width-1:0] o_ram_a1,
  output logic [d_width-1:0] o_ram_d1,
  output logic               o_ram_wen1,
  output logic [a_width-1:0] o_ram_a2,
  output logic [d_width-1:0] o_ram_d2,
  output logic               o_ram_wen2,
  input  logic [d_width-1:0] i_ram_q2
);
  localparam logic [a_width:0] DEPTH = (a_width+1)'(a_depth);

  logic [a_width-1:0] r_wr_ptr;
  logic [a_width-1:0] r_rd_ptr;
  logic [a_width:0]   r_count;
  logic               r_rd_valid;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;

  // Acceptance uses pre-edge occupancy, so push+pop at full/empty rejects one side.
  always_comb begin
    w_full   = (r_count == DEPTH);
    w_empty  = (r_count == '0);
    w_wr_acc = bus.wr_req & ~w_full  & ~i_rst;
    w_rd_acc = bus.rd_req & ~w_empty & ~i_rst;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + a_width'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + a_width'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (a_width+1)'(1);
        2'b01:   r_count <= r_count - (a_width+1)'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid <= w_rd_acc;
      if (bus.wr_req && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_req && w_empty) r_underflow <= 1'b1;
    end
  end

  always_comb begin
    bus.dout      = i_ram_q2;
    bus.rd_valid  = r_rd_valid;
    bus.full      = w_full;
    bus.empty     = w_empty;
    bus.count     = r_count;
    bus.overflow  = r_overflow;
    bus.underflow = r_underflow;
    o_ram_a1      = r_wr_ptr;
    o_ram_d1      = bus.din;
    o_ram_wen1    = w_wr_acc;
    o_ram_a2      = r_rd_ptr;
    o_ram_d2      = '0;
    o_ram_wen2    = 1'b0;
  end
endmodule
